ad_gpio_in_debounce: RTL and testbench

//  Input-side GPIO conditioner: samples asynchronous board inputs (push-buttons, DIP switches),

---
 rtl/ad_gpio_in_debounce_pkg.sv | 18 +
 rtl/ad_gpio_in_debounce_db_bit.sv | 64 ++++++
 rtl/ad_gpio_in_debounce.sv | 81 ++++++++
 tb/tb_ad_gpio_in_debounce.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ad_gpio_in_debounce_pkg.sv
// Shared constants, edge encoding and counter sizing for the GPIO input debouncer.
package ad_gpio_in_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_t;

    // Counter must hold 0..DEBOUNCE_CYCLES; floor of 1 bit keeps degenerate sizes legal.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/ad_gpio_in_debounce_db_bit.sv
// One input bit: multi-flop synchronizer, disagreement counter, debounced level and
// registered edge pulses aligned with the cycle the new level first appears.
module ad_gpio_in_db_bit
    import ad_gpio_in_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic gpio_in,
    output logic gpio_db,
    output logic gpio_rise,
    output logic gpio_fall
);

    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_db;
    edge_t                  r_edge;

    logic  w_s;
    logic  w_update;
    edge_t w_edge;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_update = (w_s != r_db) && (r_cnt == CNT_LAST);
        w_edge   = EDGE_NONE;
        if (w_update) begin
            w_edge = w_s ? EDGE_RISE : EDGE_FALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_edge <= EDGE_NONE;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
            r_edge <= w_edge;
            // Any agreement restarts the count, so the counter never needs to saturate.
            if (w_s == r_db) begin
                r_cnt <= '0;
            end else if (w_update) begin
                r_db  <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign gpio_db   = r_db;
    assign gpio_rise = (r_edge == EDGE_RISE);
    assign gpio_fall = (r_edge == EDGE_FALL);

endmodule

// File: rtl/ad_gpio_in_debounce.sv
// GPIO input conditioner: per-bit debounce plus sticky rise/fall interrupt status.
// Status/irq logic is present only when AD_GPIO_IN_DEBOUNCE_IRQ_EN is defined.
module ad_gpio_in_debounce
    import ad_gpio_in_pkg::*;
#(
    parameter int DATA_WIDTH      = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_db,
    output logic [DATA_WIDTH-1:0] gpio_rise,
    output logic [DATA_WIDTH-1:0] gpio_fall,
    input  logic [DATA_WIDTH-1:0] irq_rise_en,
    input  logic [DATA_WIDTH-1:0] irq_fall_en,
    input  logic [DATA_WIDTH-1:0] irq_clr,
    output logic [DATA_WIDTH-1:0] irq_status,
    output logic                  irq
);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("ad_gpio_in_debounce: DEBOUNCE_CYCLES must be >= 1");
        end
        if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync
            $error("ad_gpio_in_debounce: SYNC_STAGES out of range 2..4");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] w_db;
    logic [DATA_WIDTH-1:0] w_rise;
    logic [DATA_WIDTH-1:0] w_fall;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi = gi + 1) begin : g_bit
            ad_gpio_in_db_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_db_bit (
                .clk       (clk),
                .rst       (rst),
                .gpio_in   (gpio_in[gi]),
                .gpio_db   (w_db[gi]),
                .gpio_rise (w_rise[gi]),
                .gpio_fall (w_fall[gi])
            );
        end
    endgenerate

    assign gpio_db   = w_db;
    assign gpio_rise = w_rise;
    assign gpio_fall = w_fall;

`ifdef AD_GPIO_IN_DEBOUNCE_IRQ_EN
    logic [DATA_WIDTH-1:0] r_irq_status;

    // Set terms are OR'd after the clear mask, so a new edge beats a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_status <= '0;
        end else begin
            r_irq_status <= (r_irq_status & ~irq_clr)
                          | (w_rise & irq_rise_en)
                          | (w_fall & irq_fall_en);
        end
    end

    assign irq_status = r_irq_status;
    assign irq        = |r_irq_status;
`else
    logic w_unused_irq_inputs;

    assign w_unused_irq_inputs = ^{irq_rise_en, irq_fall_en, irq_clr};
    assign irq_status          = '0;
    assign irq                 = 1'b0;
`endif

endmodule

// File: tb/tb_ad_gpio_in_debounce.sv
// Scoreboard bench for ad_gpio_in_debounce (DATA_WIDTH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_ad_gpio_in_debounce;

    localparam bit IRQ_ON =
`ifdef AD_GPIO_IN_DEBOUNCE_IRQ_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] gpio_in;
    logic [2:0] gpio_db;
    logic [2:0] gpio_rise;
    logic [2:0] gpio_fall;
    logic [2:0] irq_rise_en;
    logic [2:0] irq_fall_en;
    logic [2:0] irq_clr;
    logic [2:0] irq_status;
    logic       irq;

    int cyc     = 0;
    int n_check = 0;
    int n_pass  = 0;

    typedef struct {
        int         due;
        string      tag;
        logic [2:0] db;
        logic [2:0] rise;
        logic [2:0] fall;
        logic [2:0] st;
    } exp_t;

    exp_t sb_q[$];

    ad_gpio_in_debounce #(
        .DATA_WIDTH      (3),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gpio_in     (gpio_in),
        .gpio_db     (gpio_db),
        .gpio_rise   (gpio_rise),
        .gpio_fall   (gpio_fall),
        .irq_rise_en (irq_rise_en),
        .irq_fall_en (irq_fall_en),
        .irq_clr     (irq_clr),
        .irq_status  (irq_status),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Expected outputs at (current cycle + ofs); status collapses to 0 without the irq build.
    task automatic expect_at(input string tag, input int ofs, input logic [2:0] db,
                             input logic [2:0] rise, input logic [2:0] fall, input logic [2:0] st);
        exp_t e;
        e.due  = cyc + ofs;
        e.tag  = tag;
        e.db   = db;
        e.rise = rise;
        e.fall = fall;
        e.st   = IRQ_ON ? st : 3'b000;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check_val({e.tag, ".db"},   32'(gpio_db),    32'(e.db));
            check_val({e.tag, ".rise"}, 32'(gpio_rise),  32'(e.rise));
            check_val({e.tag, ".fall"}, 32'(gpio_fall),  32'(e.fall));
            check_val({e.tag, ".st"},   32'(irq_status), 32'(e.st));
            check_val({e.tag, ".irq"},  32'(irq),        32'(|e.st));
            $display("txn %s @%0d db=%b rise=%b fall=%b st=%b irq=%b",
                     e.tag, cyc, gpio_db, gpio_rise, gpio_fall, irq_status, irq);
        end
    end

    initial begin
        rst         = 1'b1;
        gpio_in     = 3'b000;
        irq_rise_en = 3'b000;
        irq_fall_en = 3'b000;
        irq_clr     = 3'b000;

        step(3);
        expect_at("reset", 0, 3'b000, 3'b000, 3'b000, 3'b000);
        rst = 1'b0;
        step(2);

        // Clean rise and fall on bit 0: six edges of latency, one-cycle pulses.
        gpio_in = 3'b001;
        expect_at("rise0_pre",  5, 3'b000, 3'b000, 3'b000, 3'b000);
        expect_at("rise0",      6, 3'b001, 3'b001, 3'b000, 3'b000);
        expect_at("rise0_post", 7, 3'b001, 3'b000, 3'b000, 3'b000);
        step(8);
        gpio_in = 3'b000;
        expect_at("fall0_pre",  5, 3'b001, 3'b000, 3'b000, 3'b000);
        expect_at("fall0",      6, 3'b000, 3'b000, 3'b001, 3'b000);
        expect_at("fall0_post", 7, 3'b000, 3'b000, 3'b000, 3'b000);
        step(8);

        // Three-cycle glitch on bit 1 is shorter than the debounce window.
        gpio_in = 3'b010;
        expect_at("glitch_a",  6, 3'b000, 3'b000, 3'b000, 3'b000);
        expect_at("glitch_b",  8, 3'b000, 3'b000, 3'b000, 3'b000);
        expect_at("glitch_c", 10, 3'b000, 3'b000, 3'b000, 3'b000);
        step(3);
        gpio_in = 3'b000;
        step(10);

        // Rise-enabled status on bit 2, clear, then clear coincident with a new rise.
        irq_rise_en = 3'b100;
        gpio_in     = 3'b100;
        expect_at("irq_rise", 6, 3'b100, 3'b100, 3'b000, 3'b000);
        expect_at("irq_set",  7, 3'b100, 3'b000, 3'b000, 3'b100);
        step(9);
        expect_at("irq_held", 0, 3'b100, 3'b000, 3'b000, 3'b100);
        irq_clr = 3'b100;
        step(1);
        irq_clr = 3'b000;
        expect_at("irq_cleared", 0, 3'b100, 3'b000, 3'b000, 3'b000);
        gpio_in = 3'b000;
        expect_at("fall2_noirq", 6, 3'b000, 3'b000, 3'b100, 3'b000);
        step(8);
        gpio_in = 3'b100;
        expect_at("setwin_pre", 6, 3'b100, 3'b100, 3'b000, 3'b000);
        step(6);
        irq_clr = 3'b100;
        step(1);
        irq_clr = 3'b000;
        expect_at("setwin", 0, 3'b100, 3'b000, 3'b000, 3'b100);
        step(2);
        expect_at("setwin_hold", 0, 3'b100, 3'b000, 3'b000, 3'b100);

        // Reset while bit 0 is mid-count; both held-high bits rise six edges after release.
        gpio_in = 3'b101;
        step(4);
        expect_at("pre_rst", 0, 3'b100, 3'b000, 3'b000, 3'b100);
        rst = 1'b1;
        step(1);
        expect_at("in_rst", 0, 3'b000, 3'b000, 3'b000, 3'b000);
        rst = 1'b0;
        expect_at("rst_pre",  5, 3'b000, 3'b000, 3'b000, 3'b000);
        expect_at("rst_rise", 6, 3'b101, 3'b101, 3'b000, 3'b000);
        expect_at("rst_post", 7, 3'b101, 3'b000, 3'b000, 3'b100);
        step(10);

        for (int i = 0; i < 100 && sb_q.size() > 0; i++) step(1);
        check_val("drain", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
